// File: rtl/cs_fringe_sched_if.sv
// Signal bundle between mission-clock event detectors, the fringe scheduler and the
// fringe get/put driver. The scheduler uses the slave view; the driver/bench side uses master.
interface cs_fringe_sched_if #(
  parameter int N_EV = 4,
  parameter int EW   = 2
);
  logic [N_EV-1:0] ev_req_i;
  logic [N_EV-1:0] ev_dir_i;
  logic [N_EV-1:0] freeze_clk_o;
  logic            xfer_start_o;
  logic [EW-1:0]   xfer_event_o;
  logic            xfer_dir_o;
  logic            xfer_done_i;
  logic [N_EV-1:0] rcv_valid_o;
  logic            busy_o;
  logic            wd_err_o;

  modport slave (
    input  ev_req_i, ev_dir_i, xfer_done_i,
    output freeze_clk_o, xfer_start_o, xfer_event_o, xfer_dir_o, rcv_valid_o, busy_o, wd_err_o
  );

  modport master (
    output ev_req_i, ev_dir_i, xfer_done_i,
    input  freeze_clk_o, xfer_start_o, xfer_event_o, xfer_dir_o, rcv_valid_o, busy_o, wd_err_o
  );
endinterface

// File: rtl/cs_fringe_sched.sv
// Shares the single fringe port among N_EV frozen mission-clock events, one transfer at a time.
// Define CS_SCHED_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
module cs_fringe_sched #(
  parameter int N_EV   = 4,
  parameter int EW     = 2,
  parameter int WD_MAX = 100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cs_fringe_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [15:0] WD_LIM = 16'(WD_MAX);

  state_t              state_q, state_d;
  logic [N_EV-1:0]     pend_q, pend_d;
  logic [N_EV-1:0]     dir_q, dir_d;
  logic [N_EV-1:0]     rcv_q, rcv_d;
  logic [EW-1:0]       rr_q, rr_d;
  logic [EW-1:0]       ev_q, ev_d;
  logic                xdir_q, xdir_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [15:0]         wd_cnt_q, wd_cnt_d;
  logic [15:0]         wd_inc_s;
  logic                wd_hit_s;
  logic                win_found_s;
  logic [EW-1:0]       win_s;
  logic [N_EV-1:0]     new_req_s;
  logic [N_EV-1:0]     clr_s;
  logic [2*N_EV-1:0]   pend_dbl_s;
  logic [N_EV-1:0]     pend_rot_s;

  assign wd_inc_s = (wd_cnt_q == 16'hFFFF) ? 16'hFFFF : (wd_cnt_q + 16'd1);
  assign wd_hit_s = (wd_inc_s == WD_LIM);

  // Winner search: rotate pending so rr_q sits at bit 0, then take the lowest set bit.
  always_comb begin
    logic [EW:0] sum_v;
    sum_v       = {(EW+1){1'b0}};
    pend_dbl_s  = {pend_q, pend_q} >> rr_q;
    pend_rot_s  = pend_dbl_s[N_EV-1:0];
    win_found_s = 1'b0;
    win_s       = {EW{1'b0}};
    for (int k = N_EV - 1; k >= 0; k--) begin
      if (pend_rot_s[k]) begin
        sum_v = {1'b0, rr_q} + (EW+1)'(k);
        if (sum_v >= (EW+1)'(N_EV)) begin
          sum_v = sum_v - (EW+1)'(N_EV);
        end else begin
          sum_v = sum_v;
        end
        win_found_s = 1'b1;
        win_s       = sum_v[EW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic; a done in the last allowed WAIT cycle beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.xfer_done_i) begin
          state_d = IDLE;
        end else if (wd_hit_s) begin
          state_d = ERR;
        end else begin
          state_d = WAIT;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    ev_d      = ev_q;
    xdir_d    = xdir_q;
    rr_d      = rr_q;
    wd_cnt_d  = wd_cnt_q;
    rcv_d     = {N_EV{1'b0}};
    clr_s     = {N_EV{1'b0}};
    new_req_s = bus.ev_req_i & ~pend_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          ev_d   = win_s;
          xdir_d = dir_q[win_s];
        end else begin
          ev_d   = ev_q;
        end
      end
      ISSUE: wd_cnt_d = 16'd0;
      WAIT: begin
        if (bus.xfer_done_i) begin
          clr_s[ev_q] = 1'b1;
          rcv_d[ev_q] = ~dir_q[ev_q];
`ifdef CS_SCHED_FIXED_PRIO_EN
          rr_d = {EW{1'b0}};
`else
          rr_d = (ev_q == EW'(N_EV - 1)) ? {EW{1'b0}} : (ev_q + EW'(1));
`endif
        end else begin
          wd_cnt_d = wd_inc_s;
        end
      end
      ERR:     wd_cnt_d = wd_cnt_q;
      default: wd_cnt_d = wd_cnt_q;
    endcase
    // A fresh request for the event being completed keeps it pending (set wins).
    pend_d  = (pend_q & ~clr_s) | bus.ev_req_i;
    dir_d   = (dir_q & ~new_req_s) | (bus.ev_dir_i & new_req_s);
    start_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
    err_d   = (state_d == ERR);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= {N_EV{1'b0}};
      dir_q    <= {N_EV{1'b0}};
      rcv_q    <= {N_EV{1'b0}};
      rr_q     <= {EW{1'b0}};
      ev_q     <= {EW{1'b0}};
      xdir_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      wd_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      rcv_q    <= rcv_d;
      rr_q     <= rr_d;
      ev_q     <= ev_d;
      xdir_q   <= xdir_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign bus.freeze_clk_o = pend_q;
  assign bus.xfer_start_o = start_q;
  assign bus.xfer_event_o = ev_q;
  assign bus.xfer_dir_o   = xdir_q;
  assign bus.rcv_valid_o  = rcv_q;
  assign bus.busy_o       = busy_q;
  assign bus.wd_err_o     = err_q;

endmodule

// File: tb/tb_cs_fringe_sched.sv
// Directed bench for cs_fringe_sched: a transaction-level scheduler model checked every cycle,
// plus hand-computed expectations for latency, fairness, watchdog, set-wins and reset.
module tb_cs_fringe_sched;
  localparam int N  = 4;
  localparam int EW = 2;
  localparam int WD = 5;
`ifdef CS_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_ERR   = 3;

  logic clk = 1'b0;
  logic rst;
  cs_fringe_sched_if #(.N_EV(N), .EW(EW)) bus ();
  cs_fringe_sched #(.N_EV(N), .EW(EW), .WD_MAX(WD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int grants[$];

  // responder controls
  bit resp_en  = 1'b1;
  int resp_dly = 3;
  int resp_cnt = 0;
  bit stray    = 1'b0;

  // model state
  bit m_pend[N];
  bit m_dir[N];
  bit m_rcv[N];
  int m_rr, m_phase, m_g, m_wait;
  bit m_gdir;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick_next();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (m_pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0; m_dir[i] = 1'b0; m_rcv[i] = 1'b0;
    end
    m_rr = 0; m_phase = PH_IDLE; m_g = 0; m_gdir = 1'b0; m_wait = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] din, input logic done);
    bit was[N];
    int g;
    for (int i = 0; i < N; i++) begin
      was[i] = m_pend[i];
      m_rcv[i] = 1'b0;
    end
    case (m_phase)
      PH_IDLE: begin
        g = pick_next();
        if (g >= 0) begin
          m_g = g; m_gdir = m_dir[g]; m_phase = PH_ISSUE;
        end
      end
      PH_ISSUE: begin
        m_wait = 0; m_phase = PH_WAIT;
      end
      PH_WAIT: begin
        if (done) begin
          m_pend[m_g] = 1'b0;
          m_rcv[m_g]  = !m_dir[m_g];
          m_rr        = FIXED ? 0 : (m_g + 1) % N;
          m_phase     = PH_IDLE;
        end else begin
          m_wait++;
          if (m_wait >= WD) m_phase = PH_ERR;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (!was[i]) m_dir[i] = din[i];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  // model: advances on every clock edge, resets asynchronously
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(bus.ev_req_i, bus.ev_dir_i, bus.xfer_done_i);
    end
  end

  // compare DUT against model mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic [N-1:0] ef, er;
        for (int i = 0; i < N; i++) begin
          ef[i] = m_pend[i];
          er[i] = m_rcv[i];
        end
        chk("cmp_freeze", 32'(bus.freeze_clk_o), 32'(ef));
        chk("cmp_rcv",    32'(bus.rcv_valid_o),  32'(er));
        chk("cmp_start",  32'(bus.xfer_start_o), 32'(m_phase == PH_ISSUE));
        chk("cmp_busy",   32'(bus.busy_o),       32'(m_phase != PH_IDLE));
        chk("cmp_wderr",  32'(bus.wd_err_o),     32'(m_phase == PH_ERR));
        chk("cmp_event",  32'(bus.xfer_event_o), 32'(m_g));
        chk("cmp_dir",    32'(bus.xfer_dir_o),   32'(m_gdir));
        if (bus.xfer_start_o) grants.push_back(int'(bus.xfer_event_o));
      end
    end
  end

  // fringe driver stand-in: done a fixed number of cycles after each start
  initial begin
    bus.xfer_done_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.xfer_done_i = stray;
      if (resp_cnt != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) bus.xfer_done_i = 1'b1;
      end
      if (resp_en && bus.xfer_start_o) resp_cnt = resp_dly - 1;
    end
  end

  task automatic req(input logic [N-1:0] r, input logic [N-1:0] d);
    bus.ev_req_i = r;
    bus.ev_dir_i = d;
    @(negedge clk);
    bus.ev_req_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((bus.busy_o || bus.freeze_clk_o != '0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("idle_within_budget", 32'(c < budget), 32'd1);
  endtask

  task automatic stray_done();
    @(posedge clk);
    #1 stray = 1'b1;
    @(posedge clk);
    #1 stray = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int exp_g[6];
    exp_g = '{0, 1, 2, 3, 0, 2};
    rst = 1'b1;
    bus.ev_req_i = '0;
    bus.ev_dir_i = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_freeze", 32'(bus.freeze_clk_o), 32'd0);
    chk("rst_busy",   32'(bus.busy_o),       32'd0);
    chk("rst_start",  32'(bus.xfer_start_o), 32'd0);
    chk("rst_wderr",  32'(bus.wd_err_o),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single get
    req(4'b0001, 4'b0000);
    chk("t1_freeze_set", 32'(bus.freeze_clk_o), 32'h1);
    chk("t1_no_start_yet", 32'(bus.xfer_start_o), 32'd0);
    @(negedge clk);
    chk("t1_start", 32'(bus.xfer_start_o), 32'd1);
    chk("t1_event", 32'(bus.xfer_event_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_freeze_before_done", 32'(bus.freeze_clk_o), 32'h1);
    @(negedge clk);
    chk("t1_freeze_rel", 32'(bus.freeze_clk_o), 32'h0);
    chk("t1_rcv", 32'(bus.rcv_valid_o), 32'h1);
    @(negedge clk);
    chk("t1_rcv_pulse_end", 32'(bus.rcv_valid_o), 32'h0);

    // put
    req(4'b0010, 4'b0010);
    @(negedge clk);
    chk("t2_start", 32'(bus.xfer_start_o), 32'd1);
    chk("t2_event", 32'(bus.xfer_event_o), 32'd1);
    chk("t2_dir",   32'(bus.xfer_dir_o),   32'd1);
    repeat (3) @(negedge clk);
    chk("t2_freeze_rel", 32'(bus.freeze_clk_o), 32'h0);
    chk("t2_no_rcv", 32'(bus.rcv_valid_o), 32'h0);

    // fairness
    do_reset();
    grants.delete();
    req(4'b1111, 4'b0000);
    wait_idle(60);
    req(4'b0101, 4'b0000);
    wait_idle(30);
    chk("t3_count", 32'(grants.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_grant%0d", k), (k < grants.size()) ? 32'(grants[k]) : 32'hFFFF_FFFF, 32'(exp_g[k]));

    // done on the last allowed WAIT cycle must beat the watchdog
    resp_dly = 6;
    req(4'b0010, 4'b0010);
    wait_idle(30);
    chk("bnd_no_wderr", 32'(bus.wd_err_o), 32'd0);
    resp_dly = 3;

    // set wins over completion
    bus.ev_req_i = 4'b0001;
    bus.ev_dir_i = 4'b0000;
    @(negedge clk);
    bus.ev_req_i = '0;
    @(negedge clk);
    chk("t5_start1", 32'(bus.xfer_start_o), 32'd1);
    repeat (2) @(negedge clk);
    bus.ev_req_i = 4'b0001;
    @(negedge clk);
    bus.ev_req_i = '0;
    chk("t5_freeze_kept", 32'(bus.freeze_clk_o), 32'h1);
    chk("t5_rcv", 32'(bus.rcv_valid_o), 32'h1);
    @(negedge clk);
    chk("t5_start2", 32'(bus.xfer_start_o), 32'd1);
    chk("t5_event2", 32'(bus.xfer_event_o), 32'd0);
    wait_idle(30);

    // watchdog
    do_reset();
    resp_en = 1'b0;
    req(4'b0100, 4'b0000);
    repeat (6) @(negedge clk);
    chk("t4_no_err_yet", 32'(bus.wd_err_o), 32'd0);
    @(negedge clk);
    chk("t4_wderr", 32'(bus.wd_err_o), 32'd1);
    chk("t4_freeze_held", 32'(bus.freeze_clk_o), 32'h4);
    req(4'b1000, 4'b1000);
    repeat (5) @(negedge clk);
    chk("t4_freeze3", 32'(bus.freeze_clk_o), 32'hC);
    chk("t4_err_sticky", 32'(bus.wd_err_o), 32'd1);

    // async reset mid-transfer
    do_reset();
    resp_en = 1'b1;
    resp_dly = 4;
    stray_done();
    chk("t6_stray_ignored", 32'(bus.busy_o), 32'd0);
    req(4'b0110, 4'b0100);
    @(negedge clk);
    chk("t6_event", 32'(bus.xfer_event_o), 32'd1);
    @(negedge clk);
    chk("t6_freeze", 32'(bus.freeze_clk_o), 32'h6);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_freeze", 32'(bus.freeze_clk_o), 32'h0);
    chk("t6_rst_busy",   32'(bus.busy_o),       32'd0);
    chk("t6_rst_event",  32'(bus.xfer_event_o), 32'd0);
    chk("t6_rst_start",  32'(bus.xfer_start_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req(4'b1000, 4'b1000);
    @(negedge clk);
    chk("t6_start", 32'(bus.xfer_start_o), 32'd1);
    chk("t6_event3", 32'(bus.xfer_event_o), 32'd3);
    chk("t6_dir3", 32'(bus.xfer_dir_o), 32'd1);
    wait_idle(40);
    chk("t6_no_wderr", 32'(bus.wd_err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
